ex_stage_alu: RTL and testbench

- Execute stage of the 5-stage pipelined CPU; sits directly downstream of the ALU control decoder and consumes its 3-bit ALU operation code.
- Selects operands with forwarding and the immediate mux, then performs the ALU operation.
- Registers the result, store data, destination register and MEM/WB control bits into the EX/MEM pipeline register, with stall and flush control.

---
 rtl/ex_stage_alu.sv | 124 ++++++++++++
 tb/tb_ex_stage_alu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_alu.sv
// Execute stage: operand forwarding, immediate mux, ALU and the
// EX/MEM pipeline register with stall/flush control.
module ex_stage_alu #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    alu_sel,
    input  logic          id_ex_valid,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] imm,
    input  logic          alu_src,
    input  logic [RW-1:0] shamt,
    input  logic [1:0]    fwd_a,
    input  logic [1:0]    fwd_b,
    input  logic [DW-1:0] mem_wb_data,
    input  logic [RW-1:0] rd_in,
    input  logic          reg_write_in,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    input  logic          stall,
    input  logic          flush,
    output logic          ex_mem_valid,
    output logic [DW-1:0] ex_mem_result,
    output logic [DW-1:0] ex_mem_store_data,
    output logic [RW-1:0] ex_mem_rd,
    output logic          ex_mem_reg_write,
    output logic          ex_mem_mem_read,
    output logic          ex_mem_mem_write,
    output logic          ex_mem_zero,
    output logic          ex_mem_ovf
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    logic [DW-1:0] op_a;
    logic [DW-1:0] rt_fwd;
    logic [DW-1:0] op_b;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic [DW-1:0] alu_res;
    logic          alu_ovf;

    // Forwarding muxes; 11 falls back to the register-file value.
    always_comb begin
        op_a = rs_data;
        unique case (fwd_a)
            2'b01:   op_a = mem_wb_data;
            2'b10:   op_a = ex_mem_result;
            default: op_a = rs_data;
        endcase
        rt_fwd = rt_data;
        unique case (fwd_b)
            2'b01:   rt_fwd = mem_wb_data;
            2'b10:   rt_fwd = ex_mem_result;
            default: rt_fwd = rt_data;
        endcase
        op_b = alu_src ? imm : rt_fwd;
    end

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // ALU result and signed-overflow flag for ADD/SUB only.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (alu_sel)
            OP_NOP: alu_res = '0;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[DW-1] == op_b[DW-1]) &&
                          (sum[DW-1] != op_a[DW-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[DW-1] != op_b[DW-1]) &&
                          (diff[DW-1] != op_a[DW-1]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SLT: alu_res = {{(DW-1){1'b0}},
                               ($signed(op_a) < $signed(op_b))};
            OP_SLL: alu_res = op_b << shamt;
            default: alu_res = '0;
        endcase
    end

    // EX/MEM register: reset, then flush (kills control), then stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_result     <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd         <= '0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_zero       <= 1'b0;
            ex_mem_ovf        <= 1'b0;
        end else if (flush || !stall) begin
            ex_mem_result     <= alu_res;
            ex_mem_store_data <= rt_fwd;
            ex_mem_rd         <= rd_in;
            ex_mem_zero       <= (alu_res == '0);
            ex_mem_ovf        <= alu_ovf;
            ex_mem_valid      <= id_ex_valid && !flush;
            ex_mem_reg_write  <= reg_write_in && id_ex_valid && !flush;
            ex_mem_mem_read   <= mem_read_in && id_ex_valid && !flush;
            ex_mem_mem_write  <= mem_write_in && id_ex_valid && !flush;
        end
    end

endmodule

// File: tb/tb_ex_stage_alu.sv
// Scoreboard bench for ex_stage_alu: a reference model predicts the
// EX/MEM register after each edge; predictions are queued and checked.
module tb_ex_stage_alu;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    alu_sel;
    logic          id_ex_valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          alu_src;
    logic [RW-1:0] shamt;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [DW-1:0] mem_wb_data;
    logic [RW-1:0] rd_in;
    logic          reg_write_in;
    logic          mem_read_in;
    logic          mem_write_in;
    logic          stall;
    logic          flush;
    logic          ex_mem_valid;
    logic [DW-1:0] ex_mem_result;
    logic [DW-1:0] ex_mem_store_data;
    logic [RW-1:0] ex_mem_rd;
    logic          ex_mem_reg_write;
    logic          ex_mem_mem_read;
    logic          ex_mem_mem_write;
    logic          ex_mem_zero;
    logic          ex_mem_ovf;

    always #5 clk = ~clk;

    ex_stage_alu #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .alu_sel(alu_sel),
        .id_ex_valid(id_ex_valid), .rs_data(rs_data),
        .rt_data(rt_data), .imm(imm), .alu_src(alu_src),
        .shamt(shamt), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_wb_data(mem_wb_data), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .stall(stall), .flush(flush),
        .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result),
        .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_zero(ex_mem_zero), .ex_mem_ovf(ex_mem_ovf)
    );

    typedef struct packed {
        logic          v;
        logic [DW-1:0] res;
        logic [DW-1:0] sd;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          z;
        logic          o;
    } exm_t;

    typedef struct {
        exm_t e;
        bit   data;
    } sb_t;

    exm_t m;
    sb_t  q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag,
                         input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fsel(input logic [1:0] s,
                                           input logic [DW-1:0] rf);
        if (s == 2'b01) return mem_wb_data;
        if (s == 2'b10) return m.res;
        return rf;
    endfunction

    task automatic step();
        exm_t n;
        sb_t x;
        logic [DW-1:0] a, rtf, b, r;
        longint s;
        logic o;
        bit data;
        a = fsel(fwd_a, rs_data);
        rtf = fsel(fwd_b, rt_data);
        b = alu_src ? imm : rtf;
        o = 1'b0;
        r = '0;
        s = 0;
        case (alu_sel)
            3'd1: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
            end
            3'd2: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd7: r = b << shamt;
            default: r = '0;
        endcase
        if (alu_sel == 3'd1 || alu_sel == 3'd2)
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        n = m;
        data = 1'b1;
        if (!rst_n) begin
            n = '0;
        end else if (flush || !stall) begin
            n.res = r;
            n.sd  = rtf;
            n.rd  = rd_in;
            n.z   = (r == 0);
            n.o   = o;
            n.v   = id_ex_valid & ~flush;
            n.rw  = reg_write_in & id_ex_valid & ~flush;
            n.mr  = mem_read_in & id_ex_valid & ~flush;
            n.mw  = mem_write_in & id_ex_valid & ~flush;
            data  = !flush;
        end
        q.push_back('{n, data});
        @(posedge clk);
        #1;
        m = n;
        x = q.pop_front();
        check("valid", 32'(ex_mem_valid), 32'(x.e.v));
        check("reg_write", 32'(ex_mem_reg_write), 32'(x.e.rw));
        check("mem_read", 32'(ex_mem_mem_read), 32'(x.e.mr));
        check("mem_write", 32'(ex_mem_mem_write), 32'(x.e.mw));
        if (x.data) begin
            check("result", ex_mem_result, x.e.res);
            check("store_data", ex_mem_store_data, x.e.sd);
            check("rd", 32'(ex_mem_rd), 32'(x.e.rd));
            check("zero", 32'(ex_mem_zero), 32'(x.e.z));
            check("ovf", 32'(ex_mem_ovf), 32'(x.e.o));
        end
    endtask

    task automatic op(input logic [2:0] sel,
                      input logic [DW-1:0] a,
                      input logic [DW-1:0] b);
        rst_n = 1'b1;
        alu_sel = sel;
        rs_data = a;
        rt_data = b;
        alu_src = 1'b0;
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        id_ex_valid = 1'b1;
        reg_write_in = 1'b1;
        mem_read_in = 1'b0;
        mem_write_in = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        shamt = '0;
        rd_in = 5'd3;
    endtask

    task automatic randomize_inputs();
        alu_sel = 3'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
        imm = $urandom;
        alu_src = 1'($urandom);
        shamt = 5'($urandom);
        fwd_a = 2'($urandom);
        fwd_b = 2'($urandom);
        mem_wb_data = $urandom;
        rd_in = 5'($urandom);
        id_ex_valid = 1'($urandom);
        reg_write_in = 1'($urandom);
        mem_read_in = 1'($urandom);
        mem_write_in = 1'($urandom);
    endtask

    initial begin
        m = '0;
        randomize_inputs();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        repeat (2) step();

        op(3'd5, 32'hA5A5_0000, 32'h0000_5A5A);
        mem_write_in = 1'b1;
        step();
        randomize_inputs();
        rst_n = 1'b0;
        stall = 1'b1;
        repeat (2) step();
        check("rst_stall_res", ex_mem_result, 32'h0);

        op(3'd1, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        check("add_ovf_res", ex_mem_result, 32'h8000_0000);
        check("add_ovf_flag", 32'(ex_mem_ovf), 32'd1);

        op(3'd2, 32'h1234, 32'h1234);
        step();
        check("sub_zero", 32'(ex_mem_zero), 32'd1);

        op(3'd6, 32'hFFFF_FFFF, 32'h1);
        step();
        check("slt_neg", ex_mem_result, 32'd1);
        op(3'd6, 32'h8000_0000, 32'h1);
        step();
        op(3'd6, 32'h1, 32'h8000_0000);
        step();

        op(3'd7, 32'h0, 32'h3);
        shamt = 5'd4;
        step();
        check("sll_res", ex_mem_result, 32'h30);
        op(3'd7, 32'h0, 32'hDEAD_BEEF);
        step();
        op(3'd7, 32'h0, 32'hDEAD_BEEF);
        shamt = 5'd31;
        step();
        op(3'd1, 32'h10, 32'h0);
        alu_src = 1'b1;
        imm = 32'hFFFF_FFFC;
        step();
        check("addi_res", ex_mem_result, 32'h0C);

        op(3'd1, 32'd5, 32'd6);
        step();
        op(3'd1, 32'hFFFF, 32'd1);
        fwd_a = 2'b10;
        step();
        check("fwd_exmem", ex_mem_result, 32'd12);
        op(3'd2, 32'hFFFF, 32'hFFFF);
        fwd_a = 2'b10;
        fwd_b = 2'b01;
        mem_wb_data = 32'hA;
        step();
        check("fwd_memwb", ex_mem_result, 32'd2);
        check("fwd_store", ex_mem_store_data, 32'hA);

        op(3'd1, 32'h0, 32'd1);
        fwd_a = 2'b10;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rt_data = $urandom;
            rd_in = 5'($urandom);
            step();
        end
        check("stall_hold", ex_mem_result, 32'd2);

        op(3'd4, 32'h1, 32'h2);
        mem_write_in = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
        step();
        op(3'd1, 32'h1, 32'h2);
        id_ex_valid = 1'b0;
        step();
        op(3'd2, 32'h8000_0000, 32'h1);
        step();
        op(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        step();

        for (int i = 0; i < 80; i++) begin
            randomize_inputs();
            rst_n = ($urandom_range(0, 19) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
